// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single 128x32 data SRAM: fixed priority to port 0
// with a starvation guard for port 1. Optional grant/conflict counters: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          CEN,
  output logic          WEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] D,
  output logic          OEN,
  input  logic [DW-1:0] Q,
  output logic [15:0]   stat_p0,
  output logic [15:0]   stat_p1,
  output logic [15:0]   stat_conf
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0]    wait_cnt;
  logic          starve;
  logic          pend0;
  logic          pend1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Port 0 wins a conflict unless port 1 has been blocked long enough to be starving.
  assign p0_gnt = p0_req & ~(p1_req & starve);
  assign p1_gnt = p1_req & (~p0_req | starve);

  assign sel_we    = p1_gnt ? p1_we    : p0_we;
  assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
  assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      starve    <= 1'b0;
      CEN       <= 1'b1;
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      A         <= '0;
      D         <= '0;
      pend0     <= 1'b0;
      pend1     <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      rdata     <= '0;
    end else begin
      if (p1_gnt) begin
        wait_cnt <= '0;
        starve   <= 1'b0;
      end else if (p1_req) begin
        if (wait_cnt != MAX_W)
          wait_cnt <= wait_cnt + 4'd1;
        if (wait_cnt >= MAX_W - 4'd1)
          starve <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (p0_gnt | p1_gnt) begin
        CEN <= 1'b0;
        A   <= sel_addr;
        WEN <= ~sel_we;
        OEN <= sel_we;
        if (sel_we)
          D <= sel_wdata;
      end else begin
        CEN <= 1'b1;
        WEN <= 1'b1;
        OEN <= 1'b1;
      end

      // The SRAM samples on the falling edge, so Q is ready one rising edge after issue.
      pend0     <= p0_gnt & ~p0_we;
      pend1     <= p1_gnt & ~p1_we;
      p0_rvalid <= pend0;
      p1_rvalid <= pend1;
      if (pend0 | pend1)
        rdata <= Q;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_p0   <= '0;
      stat_p1   <= '0;
      stat_conf <= '0;
    end else begin
      if (p0_gnt && stat_p0 != 16'hFFFF)
        stat_p0 <= stat_p0 + 16'd1;
      if (p1_gnt && stat_p1 != 16'hFFFF)
        stat_p1 <= stat_p1 + 16'd1;
      if (p0_req && p1_req && stat_conf != 16'hFFFF)
        stat_conf <= stat_conf + 16'd1;
    end
  end
`else
  assign stat_p0   = '0;
  assign stat_p1   = '0;
  assign stat_conf = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a falling-edge SRAM model; checks grants,
// read return timing, starvation guard, reset abort and the optional stat counters.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [6:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] rdata;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] D;
  logic [31:0] Q;
  logic [15:0] stat_p0, stat_p1, stat_conf;

  logic [31:0] mem [0:127];
  logic        preload;
  int          checks;
  int          errors;

  dmem_arbiter #(.AW(7), .DW(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .OEN(OEN), .Q(Q),
    .stat_p0(stat_p0), .stat_p1(stat_p1), .stat_conf(stat_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model clocked on ~clk; preload happens here so mem has a single writer.
  initial Q = '0;
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
      mem[0] <= 32'd15;
      mem[1] <= 32'd20;
    end else if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q <= mem[A];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r0, input logic w0, input logic [6:0] a0,
                               input logic [31:0] d0, input logic r1, input logic w1,
                               input logic [6:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    applyStimulus(0, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
  endtask

  logic prev_p1, exp_p1;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    preload = 1'b1;
    idle();
    tick(); tick();
    checkOutput("rst_cen", CEN, 1);
    checkOutput("rst_wen", WEN, 1);
    checkOutput("rst_oen", OEN, 1);
    checkOutput("rst_a", A, 0);
    checkOutput("rst_d", D, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_rv0", p0_rvalid, 0);
    checkOutput("rst_rv1", p1_rvalid, 0);
    checkOutput("rst_stat_p0", stat_p0, 0);
    preload = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("[TB] p0 read of preloaded addr 0");
    applyStimulus(1, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
    checkOutput("t1_gnt0", p0_gnt, 1);
    checkOutput("t1_gnt1", p1_gnt, 0);
    tick();
    idle();
    checkOutput("t1_cen", CEN, 0);
    checkOutput("t1_oen", OEN, 0);
    checkOutput("t1_wen", WEN, 1);
    checkOutput("t1_rv_early", p0_rvalid, 0);
    tick();
    checkOutput("t1_rv", p0_rvalid, 1);
    checkOutput("t1_rdata", rdata, 32'd15);
    checkOutput("t1_cen_off", CEN, 1);
    checkOutput("t1_oen_off", OEN, 1);
    tick();
    checkOutput("t1_rv_pulse", p0_rvalid, 0);
    checkOutput("t1_rdata_hold", rdata, 32'd15);

    $display("[TB] p1 write then p0 read of addr 4");
    applyStimulus(0, 0, 7'd0, 32'd0, 1, 1, 7'd4, 32'd30);
    checkOutput("t2_gnt1", p1_gnt, 1);
    checkOutput("t2_gnt0", p0_gnt, 0);
    tick();
    checkOutput("t2_wen", WEN, 0);
    checkOutput("t2_cen", CEN, 0);
    checkOutput("t2_oen", OEN, 1);
    checkOutput("t2_a", A, 32'd4);
    checkOutput("t2_d", D, 32'd30);
    applyStimulus(1, 0, 7'd4, 32'd0, 0, 0, 7'd0, 32'd0);
    checkOutput("t2_gnt0_rd", p0_gnt, 1);
    tick();
    idle();
    checkOutput("t2_wen_off", WEN, 1);
    checkOutput("t2_oen_rd", OEN, 0);
    tick();
    checkOutput("t2_rv", p0_rvalid, 1);
    checkOutput("t2_rdata", rdata, 32'd30);
    checkOutput("t2_rv1", p1_rvalid, 0);

    $display("[TB] both ports requesting continuously");
    applyStimulus(1, 0, 7'd0, 32'd0, 1, 0, 7'd1, 32'd0);
    prev_p1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_p1 = ((i % 5) == 4);
      checkOutput($sformatf("t3_gnt1_%0d", i), p1_gnt, exp_p1);
      checkOutput($sformatf("t3_gnt0_%0d", i), p0_gnt, !exp_p1);
      tick();
      if (i > 0) begin
        checkOutput($sformatf("t3_rv1_%0d", i), p1_rvalid, prev_p1);
        checkOutput($sformatf("t3_rv0_%0d", i), p0_rvalid, !prev_p1);
      end
      prev_p1 = exp_p1;
    end
    idle();
    tick();
    checkOutput("t3_rv1_last", p1_rvalid, 1);
    checkOutput("t3_rdata_last", rdata, 32'd20);

    $display("[TB] back-to-back p0 reads 0,1,0");
    applyStimulus(1, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
    tick();
    applyStimulus(1, 0, 7'd1, 32'd0, 0, 0, 7'd0, 32'd0);
    tick();
    checkOutput("t4_rv_a", p0_rvalid, 1);
    checkOutput("t4_rdata_a", rdata, 32'd15);
    applyStimulus(1, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
    tick();
    idle();
    checkOutput("t4_rv_b", p0_rvalid, 1);
    checkOutput("t4_rdata_b", rdata, 32'd20);
    tick();
    checkOutput("t4_rv_c", p0_rvalid, 1);
    checkOutput("t4_rdata_c", rdata, 32'd15);
    tick();
    checkOutput("t4_rv_end", p0_rvalid, 0);

    $display("[TB] reset during an in-flight p1 read");
    applyStimulus(0, 0, 7'd0, 32'd0, 1, 0, 7'd4, 32'd0);
    checkOutput("t5_gnt1", p1_gnt, 1);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    checkOutput("t5_cen", CEN, 1);
    checkOutput("t5_oen", OEN, 1);
    checkOutput("t5_a", A, 0);
    checkOutput("t5_d", D, 0);
    checkOutput("t5_rdata", rdata, 0);
    tick();
    checkOutput("t5_rv1_a", p1_rvalid, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("t5_rv1_b", p1_rvalid, 0);
    applyStimulus(1, 0, 7'd1, 32'd0, 0, 0, 7'd0, 32'd0);
    checkOutput("t5_gnt0", p0_gnt, 1);
    tick();
    idle();
    tick();
    checkOutput("t5_rv0", p0_rvalid, 1);
    checkOutput("t5_rdata_after", rdata, 32'd20);

    $display("[TB] stat counters");
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    applyStimulus(1, 0, 7'd0, 32'd0, 1, 0, 7'd1, 32'd0);
    tick();
    tick();
    applyStimulus(1, 0, 7'd0, 32'd0, 0, 0, 7'd0, 32'd0);
    tick();
    applyStimulus(0, 0, 7'd0, 32'd0, 1, 0, 7'd1, 32'd0);
    checkOutput("t6_gnt1", p1_gnt, 1);
    tick();
    tick();
    idle();
    tick();
`ifdef DMEM_ARB_STATS_EN
    checkOutput("t6_stat_p0", stat_p0, 16'd3);
    checkOutput("t6_stat_p1", stat_p1, 16'd2);
    checkOutput("t6_stat_conf", stat_conf, 16'd2);
`else
    checkOutput("t6_stat_p0", stat_p0, 16'd0);
    checkOutput("t6_stat_p1", stat_p1, 16'd0);
    checkOutput("t6_stat_conf", stat_conf, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 128x32 data SRAM (HSs18n_128x32-style port: CEN, WEN, A, D, OEN, Q) between two requesters.
- Port 0 is the SingleCycle_MIPS load/store path. Port 1 is a host/debug/DMA path used to preload or inspect data memory.
- Fixed priority to port 0, with a starvation guard that forces a port-1 grant after a bounded wait.
- All SRAM controls are registered. Read data returns on a registered valid pulse.

Parameters:
- AW, 7, SRAM word-address width.
- DW, 32, data width.
- MAX_WAIT, 4, consecutive cycles port 1 may be blocked before it gets forced priority (range 1..15).

Ports:
- clk  input  1  system clock; the SRAM is clocked by ~clk.
- rst_n  input  1  asynchronous active-low reset.
- p0_req  input  1  port-0 request.
- p0_we  input  1  port-0 write (1) / read (0).
- p0_addr  input  AW  port-0 word address.
- p0_wdata  input  DW  port-0 write data.
- p0_gnt  output  1  port-0 request accepted this cycle.
- p0_rvalid  output  1  port-0 read data valid (1-cycle pulse).
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid  same widths and meanings, for port 1.
- rdata  output  DW  registered read data, shared by both ports.
- CEN  output  1  SRAM chip enable, active low.
- WEN  output  1  SRAM write enable, active low.
- A  output  AW  SRAM address.
- D  output  DW  SRAM write data.
- OEN  output  1  SRAM output enable, active low.
- Q  input  DW  SRAM read data.
- stat_p0, stat_p1  output  16  grant counters (see Optional Feature).
- stat_conf  output  16  conflict counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - CEN=1, WEN=1, OEN=1, A=0, D=0, rdata=0.
  - p0_rvalid=p1_rvalid=0.
  - Wait counter=0, starve flag=0, all stat counters=0.
  - Reset mid-operation drops any in-flight read; no rvalid is produced for it.
- Grants:
  - gnt is combinational from req and the starve flag. At most one gnt is high per cycle.
  - A transfer is accepted on the rising edge where req&gnt=1.
  - Requesters hold req, we, addr and wdata stable until granted.
- Arbitration:
  - Only one port requests: that port is granted.
  - Both request, starve=0: port 0 is granted.
  - Both request, starve=1: port 1 is granted.
  - Neither requests: no grant.
- Wait counter (4-bit):
  - Increments on each cycle p1_req=1 and p1_gnt=0.
  - Clears on a port-1 grant or when p1_req=0.
  - When it reaches MAX_WAIT, starve is set. Starve clears on the next port-1 grant.
  - The counter saturates at MAX_WAIT and never wraps.
- Command issue, registered at edge E of acceptance:
  - CEN=0 and A=addr.
  - Write: WEN=0, D=wdata, OEN=1.
  - Read: WEN=1, OEN=0.
  - No acceptance: CEN=1, WEN=1, OEN=1; A and D hold their last values.
- Read return:
  - The SRAM samples on the falling clk edge. Q is valid before E+1.
  - At E+1: rdata<=Q and the accepting port's rvalid pulses for exactly 1 cycle.
  - rdata holds its value until the next read return.
- Throughput:
  - One access per cycle. Back-to-back reads give consecutive rvalid pulses.
  - A write directly after a read is legal; the read's rvalid is still produced.
- Writes:
  - No response beyond gnt; a write is complete at acceptance.
  - A read of the same address on the following cycle returns the new data.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - stat_p0 and stat_p1 increment on each grant of their port.
  - stat_conf increments on each cycle where both req=1.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined:
  - The counters are not built and all three stat outputs are tied to 0.
  - Arbitration and timing are identical with or without the macro.

Test Plan:
- Reset, then p0 read addr 0 with memory preloaded 15/20 at addr 0/1 -> p0_gnt=1 in the same cycle; next cycle p0_rvalid=1 and rdata=15; CEN/OEN low for exactly one cycle.
- p1 write addr 4 data 30, then p0 read addr 4 -> rdata=30 on p0_rvalid; WEN low for exactly the write cycle.
- Both ports held requesting continuously, MAX_WAIT=4 -> p0 granted for 4 cycles, p1 granted in the 5th, p0 in the 6th; pattern repeats.
- Back-to-back p0 reads of addr 0,1,0 -> rvalid high 3 consecutive cycles with rdata 15,20,15.
- rst_n pulsed low one cycle after a p1 read is accepted -> no p1_rvalid; outputs return to reset values; the next p0 read works normally.
- DMEM_ARB_STATS_EN defined, with 3 p0 grants, 2 p1 grants and 2 conflict cycles -> stat_p0=3, stat_p1=2, stat_conf=2. Macro undefined -> all three stat outputs read 0.
